// File: rtl/trap_entry_seq_if.sv
// Bus between the M-stage fault pipeline and the trap entry sequencer.
interface trap_entry_seq_if #(
    parameter int unsigned XLEN = 64
);
    logic            InstrValidM;
    logic            InstrPageFaultM;
    logic            InstrAccessFaultM;
    logic            HPTWInstrAccessFaultM;
    logic            IllegalIEUFPUInstrM;
    logic            PendingIntM;
    logic [3:0]      IntCodeM;
    logic [XLEN-1:0] PCM;
    logic [31:0]     InstrM;
    logic            BusIdleM;
    logic            RedirectAckF;
    logic            TrapStallM;
    logic            TrapM;
    logic            FlushAllM;
    logic [XLEN-1:0] CauseM;
    logic [XLEN-1:0] TvalM;
    logic            DrainTimeout;

    // Pipeline / fetch side: supplies faults and handshakes, sees trap outputs.
    modport master (
        output InstrValidM, InstrPageFaultM, InstrAccessFaultM, HPTWInstrAccessFaultM,
        output IllegalIEUFPUInstrM, PendingIntM, IntCodeM, PCM, InstrM, BusIdleM, RedirectAckF,
        input  TrapStallM, TrapM, FlushAllM, CauseM, TvalM, DrainTimeout
    );

    // Trap sequencer side.
    modport slave (
        input  InstrValidM, InstrPageFaultM, InstrAccessFaultM, HPTWInstrAccessFaultM,
        input  IllegalIEUFPUInstrM, PendingIntM, IntCodeM, PCM, InstrM, BusIdleM, RedirectAckF,
        output TrapStallM, TrapM, FlushAllM, CauseM, TvalM, DrainTimeout
    );
endinterface

// File: rtl/trap_entry_seq.sv
// Prioritizes M-stage faults and interrupts into cause/tval and sequences
// trap entry: drain bus activity, commit for one cycle, wait for redirect ack.
module trap_entry_seq #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DRAIN_MAX = 15
) (
    input logic             clk,
    input logic             reset,
    trap_entry_seq_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(DRAIN_MAX + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_MAX - 1);
    localparam logic [CntW-1:0] CntSat  = CntW'(DRAIN_MAX);

    typedef enum logic [1:0] {
        Idle     = 2'd0,
        Drain    = 2'd1,
        Commit   = 2'd2,
        Redirect = 2'd3
    } stateT;

    stateT           state;
    stateT           nextState;
    logic [CntW-1:0] drainCnt;
    logic            faultM;
    logic            eventM;
    logic            loadCause;
    logic            cntClr;
    logic            setTimeout;
    logic            stallC;
    logic [XLEN-1:0] causeSel;
    logic [XLEN-1:0] tvalSel;
    logic [XLEN-1:0] causeReg;
    logic [XLEN-1:0] tvalReg;
    logic            trapReg;
    logic            timeoutReg;

    // Trap-worthy condition; faults only count for a valid instruction.
    always_comb begin
        faultM = bus.InstrValidM & (bus.InstrPageFaultM | bus.InstrAccessFaultM |
                                    bus.HPTWInstrAccessFaultM | bus.IllegalIEUFPUInstrM);
        eventM = bus.PendingIntM | faultM;
    end

    // Cause/tval priority: interrupt, page fault, access fault, illegal instruction.
    always_comb begin
        causeSel = '0;
        tvalSel  = '0;
        if (bus.PendingIntM) begin
            causeSel[XLEN-1] = 1'b1;
            causeSel[3:0]    = bus.IntCodeM;
        end else if (bus.InstrPageFaultM) begin
            causeSel = XLEN'(12);
            tvalSel  = bus.PCM;
        end else if (bus.InstrAccessFaultM | bus.HPTWInstrAccessFaultM) begin
            causeSel = XLEN'(1);
            tvalSel  = bus.PCM;
        end else begin
            causeSel = XLEN'(2);
            tvalSel  = XLEN'(bus.InstrM);
        end
    end

    // Next-state and control decode.
    always_comb begin
        nextState  = state;
        loadCause  = 1'b0;
        cntClr     = 1'b0;
        setTimeout = 1'b0;
        unique case (state)
            Idle: begin
                if (eventM) begin
                    loadCause = 1'b1;
                    if (bus.BusIdleM) begin
                        nextState = Commit;
                    end else begin
                        nextState = Drain;
                        cntClr    = 1'b1;
                    end
                end
            end
            Drain: begin
                if (bus.BusIdleM) begin
                    nextState = Commit;
                end else if (drainCnt == CntLast) begin
                    nextState  = Commit;
                    setTimeout = 1'b1;
                end
            end
            Commit: begin
                nextState = Redirect;
            end
            Redirect: begin
                if (bus.RedirectAckF) begin
                    nextState = Idle;
                end
            end
            default: begin
                nextState = Idle;
            end
        endcase
    end

    // Stall is immediate on an event seen in Idle, then held for the whole entry.
    always_comb begin
        stallC = (state != Idle) | eventM;
    end

    // State, commit pulse, captured cause/tval and sticky timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= Idle;
            trapReg    <= 1'b0;
            causeReg   <= '0;
            tvalReg    <= '0;
            timeoutReg <= 1'b0;
        end else begin
            state   <= nextState;
            trapReg <= (nextState == Commit);
            if (loadCause) begin
                causeReg <= causeSel;
                tvalReg  <= tvalSel;
            end
            if (setTimeout) begin
                timeoutReg <= 1'b1;
            end
        end
    end

    // Drain cycle counter; cleared on entry, saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drainCnt <= '0;
        end else if (cntClr) begin
            drainCnt <= '0;
        end else if ((state == Drain) && (drainCnt != CntSat)) begin
            drainCnt <= drainCnt + CntW'(1);
        end
    end

    assign bus.TrapStallM   = stallC;
    assign bus.TrapM        = trapReg;
    assign bus.FlushAllM    = trapReg;
    assign bus.CauseM       = causeReg;
    assign bus.TvalM        = tvalReg;
    assign bus.DrainTimeout = timeoutReg;

endmodule

// File: tb/tb_trap_entry_seq.sv
// Self-checking bench for trap_entry_seq: vector table, corner sequences, random vs model.
module tb_trap_entry_seq;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned DRAIN_MAX = 15;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    trap_entry_seq_if #(.XLEN(XLEN)) bus();

    trap_entry_seq #(.XLEN(XLEN), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        pf;
        logic        af;
        logic        hptw;
        logic        ill;
        logic        intp;
        logic [3:0]  code;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        expEvent;
        logic [63:0] expCause;
        logic [63:0] expTval;
    } vecT;

    vecT vecs [9];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        bus.InstrValidM           = 1'b0;
        bus.InstrPageFaultM       = 1'b0;
        bus.InstrAccessFaultM     = 1'b0;
        bus.HPTWInstrAccessFaultM = 1'b0;
        bus.IllegalIEUFPUInstrM   = 1'b0;
        bus.PendingIntM           = 1'b0;
        bus.IntCodeM              = 4'd0;
        bus.PCM                   = 64'd0;
        bus.InstrM                = 32'd0;
        bus.BusIdleM              = 1'b1;
        bus.RedirectAckF          = 1'b0;
    endtask

    // From the COMMIT cycle: clear inputs, acknowledge, return to Idle.
    task automatic finishTrap();
        clearIn();
        bus.RedirectAckF = 1'b1;
        tick();
        tick();
        bus.RedirectAckF = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearIn();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Architectural priority rules for cause/tval.
    function automatic void prio(input logic intp, input logic [3:0] code, input logic valid,
                                 input logic pf, input logic af, input logic hptw,
                                 input logic [63:0] pc, input logic [31:0] instr,
                                 output logic [63:0] cause, output logic [63:0] tval);
        if (intp) begin
            cause = 64'h8000_0000_0000_0000 | 64'(code);
            tval  = 64'd0;
        end else if (valid && pf) begin
            cause = 64'd12;
            tval  = pc;
        end else if (valid && (af || hptw)) begin
            cause = 64'd1;
            tval  = pc;
        end else begin
            cause = 64'd2;
            tval  = 64'(instr);
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] lastCause;
        logic [63:0] lastTval;
        int          n;
        int          evC;
        int          trapC;
        int          thresh;
        bit          inTrap;
        bit          tmo;
        logic        ev;
        logic [63:0] mCause;
        logic [63:0] mTval;

        // valid pf af hptw ill intp code pc instr expEvent expCause expTval
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  64'h0, 32'hFFFF_FFFF,
                    1'b1, 64'd2, 64'hFFFF_FFFF};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  64'h8000_1000, 32'h13,
                    1'b1, 64'd12, 64'h8000_1000};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd7,  64'h40, 32'h0BAD,
                    1'b1, 64'h8000_0000_0000_0007, 64'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  64'h100, 32'h1,
                    1'b0, 64'h0, 64'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  64'h1234, 32'h0,
                    1'b1, 64'd1, 64'h1234};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  64'hDEAD_BEEF_0000_0004, 32'h7,
                    1'b1, 64'd1, 64'hDEAD_BEEF_0000_0004};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11, 64'h55, 32'h9,
                    1'b1, 64'h8000_0000_0000_000B, 64'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  64'h77, 32'hFFFF_0000,
                    1'b0, 64'h0, 64'h0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  64'hFFFF_FFFF_FFFF_FFFC, 32'h3,
                    1'b1, 64'd12, 64'hFFFF_FFFF_FFFF_FFFC};

        // Reset state
        reset = 1'b1;
        clearIn();
        tick();
        tick();
        check1("rstTrap", bus.TrapM, 1'b0);
        check1("rstFlush", bus.FlushAllM, 1'b0);
        check64("rstCause", bus.CauseM, 64'd0);
        check64("rstTval", bus.TvalM, 64'd0);
        check1("rstTimeout", bus.DrainTimeout, 1'b0);
        check1("rstStall", bus.TrapStallM, 1'b0);
        reset = 1'b0;
        tick();

        // Vector table, bus idle: trap one cycle after the event
        lastCause = 64'd0;
        lastTval  = 64'd0;
        for (int i = 0; i < 9; i++) begin
            clearIn();
            bus.InstrValidM           = vecs[i].valid;
            bus.InstrPageFaultM       = vecs[i].pf;
            bus.InstrAccessFaultM     = vecs[i].af;
            bus.HPTWInstrAccessFaultM = vecs[i].hptw;
            bus.IllegalIEUFPUInstrM   = vecs[i].ill;
            bus.PendingIntM           = vecs[i].intp;
            bus.IntCodeM              = vecs[i].code;
            bus.PCM                   = vecs[i].pc;
            bus.InstrM                = vecs[i].instr;
            #1;
            check1($sformatf("vec%0d.stall", i), bus.TrapStallM, vecs[i].expEvent);
            tick();
            check1($sformatf("vec%0d.trap", i), bus.TrapM, vecs[i].expEvent);
            check1($sformatf("vec%0d.flush", i), bus.FlushAllM, vecs[i].expEvent);
            if (vecs[i].expEvent) begin
                lastCause = vecs[i].expCause;
                lastTval  = vecs[i].expTval;
            end
            check64($sformatf("vec%0d.cause", i), bus.CauseM, lastCause);
            check64($sformatf("vec%0d.tval", i), bus.TvalM, lastTval);
            if (vecs[i].expEvent) begin
                finishTrap();
            end else begin
                clearIn();
                tick();
            end
        end

        // HPTW fault with bus busy 4 cycles: trap in cycle 6
        clearIn();
        bus.InstrValidM           = 1'b1;
        bus.HPTWInstrAccessFaultM = 1'b1;
        bus.PCM                   = 64'h2000;
        bus.BusIdleM              = 1'b0;
        #1;
        check1("drainStallEv", bus.TrapStallM, 1'b1);
        tick();
        bus.InstrValidM           = 1'b0;
        bus.HPTWInstrAccessFaultM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check1("drainStall", bus.TrapStallM, 1'b1);
            check1("drainNoTrap", bus.TrapM, 1'b0);
            tick();
        end
        bus.BusIdleM = 1'b1;
        check1("drainStallLast", bus.TrapStallM, 1'b1);
        check1("drainNoTrapLast", bus.TrapM, 1'b0);
        tick();
        check1("drainTrap", bus.TrapM, 1'b1);
        check64("drainCause", bus.CauseM, 64'd1);
        check64("drainTval", bus.TvalM, 64'h2000);
        check1("drainNoTimeout", bus.DrainTimeout, 1'b0);

        // Ack during COMMIT ignored; new fault/interrupt during REDIRECT ignored
        bus.RedirectAckF        = 1'b1;
        bus.InstrValidM         = 1'b1;
        bus.IllegalIEUFPUInstrM = 1'b1;
        bus.InstrM              = 32'h1234;
        bus.PendingIntM         = 1'b1;
        bus.IntCodeM            = 4'd5;
        tick();
        bus.RedirectAckF = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check1("redirStall", bus.TrapStallM, 1'b1);
            check1("redirNoTrap", bus.TrapM, 1'b0);
            check64("redirCause", bus.CauseM, 64'd1);
            check64("redirTval", bus.TvalM, 64'h2000);
            tick();
        end
        clearIn();
        bus.RedirectAckF = 1'b1;
        tick();
        bus.RedirectAckF = 1'b0;
        #1;
        check1("backIdleStall", bus.TrapStallM, 1'b0);
        check64("backIdleCause", bus.CauseM, 64'd1);

        // Bus never idle: forced commit DRAIN_MAX+1 cycles after the event
        clearIn();
        bus.PendingIntM = 1'b1;
        bus.IntCodeM    = 4'd3;
        bus.BusIdleM    = 1'b0;
        tick();
        bus.PendingIntM = 1'b0;
        n = 1;
        while (bus.TrapM !== 1'b1 && n < 40) begin
            check1("tmoStall", bus.TrapStallM, 1'b1);
            tick();
            n++;
        end
        check64("tmoLatency", 64'(n), 64'(DRAIN_MAX + 1));
        check1("tmoFlag", bus.DrainTimeout, 1'b1);
        check64("tmoCause", bus.CauseM, 64'h8000_0000_0000_0003);
        finishTrap();
        check1("tmoSticky", bus.DrainTimeout, 1'b1);

        // Reset asserted in REDIRECT clears everything at once
        bus.InstrValidM         = 1'b1;
        bus.IllegalIEUFPUInstrM = 1'b1;
        bus.InstrM              = 32'h5;
        tick();
        check1("preRstTrap", bus.TrapM, 1'b1);
        clearIn();
        tick();
        #1;
        reset = 1'b1;
        #1;
        check1("midRstTrap", bus.TrapM, 1'b0);
        check1("midRstFlush", bus.FlushAllM, 1'b0);
        check64("midRstCause", bus.CauseM, 64'd0);
        check64("midRstTval", bus.TvalM, 64'd0);
        check1("midRstTimeout", bus.DrainTimeout, 1'b0);
        check1("midRstStall", bus.TrapStallM, 1'b0);
        tick();
        reset = 1'b0;

        // Reset during DRAIN aborts with no trap pulse
        bus.PendingIntM = 1'b1;
        bus.BusIdleM    = 1'b0;
        tick();
        bus.PendingIntM = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.BusIdleM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check1("abortNoTrap", bus.TrapM, 1'b0);
            check1("abortNoStall", bus.TrapStallM, 1'b0);
            tick();
        end

        // Random stimulus against a cycle-time model
        doReset();
        inTrap = 1'b0;
        trapC  = -1;
        evC    = 0;
        tmo    = 1'b0;
        mCause = 64'd0;
        mTval  = 64'd0;
        thresh = 3;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 40 == 0) thresh = $urandom_range(0, 6);
            bus.InstrValidM           = 1'($urandom_range(0, 1));
            bus.InstrPageFaultM       = ($urandom_range(0, 7) == 0);
            bus.InstrAccessFaultM     = ($urandom_range(0, 7) == 0);
            bus.HPTWInstrAccessFaultM = ($urandom_range(0, 7) == 0);
            bus.IllegalIEUFPUInstrM   = ($urandom_range(0, 7) == 0);
            bus.PendingIntM           = ($urandom_range(0, 9) == 0);
            bus.IntCodeM              = 4'($urandom());
            bus.PCM                   = {$urandom(), $urandom()};
            bus.InstrM                = $urandom();
            bus.BusIdleM              = ($urandom_range(0, 9) < thresh);
            bus.RedirectAckF          = ($urandom_range(0, 2) == 0);
            ev = bus.PendingIntM | (bus.InstrValidM & (bus.InstrPageFaultM | bus.InstrAccessFaultM |
                                                       bus.HPTWInstrAccessFaultM | bus.IllegalIEUFPUInstrM));
            #1;
            check1("rndStall", bus.TrapStallM, inTrap ? 1'b1 : ev);
            if (!inTrap) begin
                if (ev) begin
                    inTrap = 1'b1;
                    evC    = cyc;
                    prio(bus.PendingIntM, bus.IntCodeM, bus.InstrValidM, bus.InstrPageFaultM,
                         bus.InstrAccessFaultM, bus.HPTWInstrAccessFaultM, bus.PCM, bus.InstrM,
                         mCause, mTval);
                    trapC = bus.BusIdleM ? cyc + 1 : -1;
                end
            end else if (trapC < 0) begin
                if (bus.BusIdleM) begin
                    trapC = cyc + 1;
                end else if (cyc - evC - 1 == int'(DRAIN_MAX) - 1) begin
                    trapC = cyc + 1;
                    tmo   = 1'b1;
                end
            end else if (cyc > trapC && bus.RedirectAckF) begin
                inTrap = 1'b0;
                trapC  = -1;
            end
            tick();
            check1("rndTrap", bus.TrapM, (trapC == cyc + 1));
            check1("rndFlush", bus.FlushAllM, (trapC == cyc + 1));
            check64("rndCause", bus.CauseM, mCause);
            check64("rndTval", bus.TvalM, mTval);
            check1("rndTimeout", bus.DrainTimeout, tmo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
